// File: rtl/io_pkg.sv
// Shared types and default channel masks for the I/O channel unit.
package io_pkg;

   localparam int IO_CH_COUNT = 16;

   typedef logic [14:0] io_word_t;
   typedef logic [3:0]  io_chan_t;

   typedef struct packed {
      io_chan_t chan;
      io_word_t data;
   } io_entry_t;

   localparam logic [15:0] IO_OUT_MASK_DEFAULT = 16'h00F0;
   localparam logic [15:0] IO_IN_MASK_DEFAULT  = 16'h0F00;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO of channel entries; a push into a full FIFO succeeds
// only when the head is popped in the same cycle.
module io_fifo
   import io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  io_entry_t              push_entry,
   output logic                   full,
   output logic                   out_valid,
   input  logic                   out_ready,
   output io_entry_t              out_entry,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: the head transfers on any edge where out_valid && out_ready;
   // out_entry holds steady while out_valid=1 and out_ready=0.
   io_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            pop;
   logic            push_ok;

   assign full      = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push_ok   = push && (!full || pop);
   assign out_entry = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/io_channel_unit.sv
// Sixteen 15-bit I/O channel registers with same-cycle read forwarding,
// peripheral-owned input channels and an outbound queue for output channels.
module io_channel_unit
   import io_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] OUT_MASK   = IO_OUT_MASK_DEFAULT,
   parameter logic [15:0] IN_MASK    = IO_IN_MASK_DEFAULT
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        IO_write_en,
   input  logic [3:0]                  IO_write_sel,
   input  logic [14:0]                 IO_write_data,
   input  logic [3:0]                  IO_read_sel,
   output logic [14:0]                 IO_read_data,
   input  logic                        in_valid,
   input  logic [3:0]                  in_chan,
   input  logic [14:0]                 in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [3:0]                  out_chan,
   output logic [14:0]                 out_data,
   input  logic                        ovf_clear,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   io_word_t  ch [IO_CH_COUNT];
   logic      core_ok;
   logic      per_ok;
   logic      push;
   logic      full;
   logic      drop;
   io_entry_t head;

   // Core and peripheral own disjoint channel sets, so both writes can land together.
   assign core_ok = IO_write_en && !IN_MASK[IO_write_sel];
   assign per_ok  = in_valid && IN_MASK[in_chan];
   assign push    = core_ok && OUT_MASK[IO_write_sel];
   assign drop    = push && full && !(out_valid && out_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < IO_CH_COUNT; i++) ch[i] <= '0;
      end else begin
         if (core_ok) ch[IO_write_sel] <= IO_write_data;
         if (per_ok)  ch[in_chan]      <= in_data;
      end
   end

   always_comb begin
      IO_read_data = ch[IO_read_sel];
      if (core_ok && (IO_write_sel == IO_read_sel)) begin
         IO_read_data = IO_write_data;
      end else if (per_ok && (in_chan == IO_read_sel)) begin
         IO_read_data = in_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clear) begin
         overflow <= 1'b0;
      end
   end

   io_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry ('{chan: IO_write_sel, data: IO_write_data}),
      .full       (full),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_entry  (head),
      .count      (fifo_count)
   );

   assign out_chan = head.chan;
   assign out_data = head.data;

endmodule

// File: tb/tb_io_channel_unit.sv
// Bench for io_channel_unit: directed scenarios plus randomized traffic
// against a queue/array reference model.
`timescale 1ns/1ps
module tb_io_channel_unit;

   localparam int          FIFO_DEPTH = 4;
   localparam logic [15:0] OUT_M      = 16'h00F0;
   localparam logic [15:0] IN_M       = 16'h0F00;

   logic        clock = 1'b0;
   logic        reset;
   logic        IO_write_en;
   logic [3:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic [3:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic        in_valid;
   logic [3:0]  in_chan;
   logic [14:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_chan;
   logic [14:0] out_data;
   logic        ovf_clear;
   logic        overflow;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [14:0] model_ch [16];
   logic [18:0] exp_q [$];
   logic        model_ovf;

   io_channel_unit #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock(clock), .reset(reset),
      .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
      .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
      .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
      .ovf_clear(ovf_clear), .overflow(overflow), .fifo_count(fifo_count)
   );

   always #50 clock = ~clock;

   task automatic drive_idle();
      IO_write_en = 1'b0; IO_write_sel = '0; IO_write_data = '0;
      in_valid = 1'b0; in_chan = '0; in_data = '0;
      out_ready = 1'b0; ovf_clear = 1'b0;
   endtask

   task automatic core_write(input logic [3:0] sel, input logic [14:0] data);
      IO_write_en = 1'b1; IO_write_sel = sel; IO_write_data = data;
   endtask

   function automatic logic [14:0] expected_read(input logic [3:0] rsel);
      if (IO_write_en && !IN_M[IO_write_sel] && IO_write_sel == rsel) return IO_write_data;
      if (in_valid && IN_M[in_chan] && in_chan == rsel) return in_data;
      return model_ch[rsel];
   endfunction

   // Apply the model for the coming edge using the present inputs, then advance.
   task automatic tick();
      logic pop_m, push_m, dropped;
      logic [18:0] gone;
      pop_m   = (exp_q.size() != 0) && out_ready;
      push_m  = IO_write_en && !IN_M[IO_write_sel] && OUT_M[IO_write_sel];
      dropped = 1'b0;
      if (reset) begin
         for (int i = 0; i < 16; i++) model_ch[i] = '0;
         exp_q.delete();
         model_ovf = 1'b0;
      end else begin
         if (pop_m) gone = exp_q.pop_front();
         if (push_m) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({IO_write_sel, IO_write_data});
            else dropped = 1'b1;
         end
         if (dropped) model_ovf = 1'b1;
         else if (ovf_clear) model_ovf = 1'b0;
         if (IO_write_en && !IN_M[IO_write_sel]) model_ch[IO_write_sel] = IO_write_data;
         if (in_valid && IN_M[in_chan]) model_ch[in_chan] = in_data;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      IO_read_sel = '0;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (out_chan !== 4'd0 || out_data !== 15'd0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", out_chan, out_data); end
      for (int i = 0; i < 16; i++) begin
         IO_read_sel = 4'(i);
         #1;
         checks++; if (IO_read_data !== 15'd0) begin errors++; $display("FAIL reset_ch%0d: got %h expected 0", i, IO_read_data); end
      end
   endtask

   task automatic test_core_write();
      drive_idle();
      core_write(4'd3, 15'h1234);
      tick();
      drive_idle();
      IO_read_sel = 4'd3;
      #1;
      checks++; if (IO_read_data !== model_ch[3]) begin errors++; $display("FAIL core_write_ch3: got %h expected %h", IO_read_data, model_ch[3]); end
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL core_write_count: got %0d expected %0d", fifo_count, exp_q.size()); end
   endtask

   task automatic test_forward_output();
      drive_idle();
      core_write(4'd5, 15'h7FFF);
      IO_read_sel = 4'd5;
      #1;
      checks++; if (IO_read_data !== expected_read(4'd5)) begin errors++; $display("FAIL forward_ch5: got %h expected %h", IO_read_data, expected_read(4'd5)); end
      tick();
      drive_idle();
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL fwd_out_valid: got %0b expected %0b", out_valid, exp_q.size() != 0); end
      checks++; if ({out_chan, out_data} !== exp_q[0]) begin errors++; $display("FAIL fwd_head: got %h/%h expected %h", out_chan, out_data, exp_q[0]); end
      out_ready = 1'b1;
      tick();
      drive_idle();
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL fwd_drain_count: got %0d expected %0d", fifo_count, exp_q.size()); end
   endtask

   task automatic test_input_channel();
      drive_idle();
      core_write(4'd9, 15'h0042);
      tick();
      drive_idle();
      IO_read_sel = 4'd9;
      #1;
      checks++; if (IO_read_data !== model_ch[9]) begin errors++; $display("FAIL in_core_ignored: got %h expected %h", IO_read_data, model_ch[9]); end
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL in_no_push: got %0d expected %0d", fifo_count, exp_q.size()); end
      in_valid = 1'b1; in_chan = 4'd9; in_data = 15'h0042;
      #1;
      checks++; if (IO_read_data !== expected_read(4'd9)) begin errors++; $display("FAIL in_forward: got %h expected %h", IO_read_data, expected_read(4'd9)); end
      tick();
      drive_idle();
      #1;
      checks++; if (IO_read_data !== model_ch[9]) begin errors++; $display("FAIL in_periph_write: got %h expected %h", IO_read_data, model_ch[9]); end
      in_valid = 1'b1; in_chan = 4'd2; in_data = 15'h5555;
      IO_read_sel = 4'd2;
      #1;
      checks++; if (IO_read_data !== expected_read(4'd2)) begin errors++; $display("FAIL in_masked_fwd: got %h expected %h", IO_read_data, expected_read(4'd2)); end
      tick();
      drive_idle();
      #1;
      checks++; if (IO_read_data !== model_ch[2]) begin errors++; $display("FAIL in_masked_ch2: got %h expected %h", IO_read_data, model_ch[2]); end
   endtask

   task automatic test_overflow();
      drive_idle();
      for (int i = 1; i <= 5; i++) begin
         core_write(4'd4, 15'(i));
         tick();
      end
      drive_idle();
      IO_read_sel = 4'd4;
      #1;
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL ovf_flag: got %0b expected %0b", overflow, model_ovf); end
      checks++; if (IO_read_data !== model_ch[4]) begin errors++; $display("FAIL ovf_ch4: got %h expected %h", IO_read_data, model_ch[4]); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (!out_valid || {out_chan, out_data} !== exp_q[0]) begin errors++; $display("FAIL ovf_pop%0d: got %0b %h/%h expected %h", i, out_valid, out_chan, out_data, exp_q[0]); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b expected 0", out_valid); end
      drive_idle();
   endtask

   task automatic test_full_with_pop();
      drive_idle();
      ovf_clear = 1'b1;
      tick();
      drive_idle();
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL fp_clear: got %0b expected %0b", overflow, model_ovf); end
      for (int i = 0; i < 4; i++) begin
         core_write(4'd7, 15'(16 + i));
         tick();
      end
      core_write(4'd7, 15'h0AAA);
      out_ready = 1'b1;
      tick();
      drive_idle();
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL fp_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL fp_overflow: got %0b expected %0b", overflow, model_ovf); end
      core_write(4'd6, 15'h0BBB);
      ovf_clear = 1'b1;
      tick();
      drive_idle();
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL fp_set_wins: got %0b expected %0b", overflow, model_ovf); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (!out_valid || {out_chan, out_data} !== exp_q[0]) begin errors++; $display("FAIL fp_pop%0d: got %0b %h/%h expected %h", i, out_valid, out_chan, out_data, exp_q[0]); end
         tick();
      end
      drive_idle();
   endtask

   task automatic test_reset_mid_transfer();
      drive_idle();
      core_write(4'd4, 15'h0011); tick();
      core_write(4'd5, 15'h0022); tick();
      core_write(4'd6, 15'h0101); tick();
      drive_idle();
      checks++; if (fifo_count !== 3'(exp_q.size())) begin errors++; $display("FAIL rst_pre_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      reset = 1'b1;
      out_ready = 1'b1;
      tick();
      reset = 1'b0;
      drive_idle();
      IO_read_sel = 4'd6;
      #1;
      checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_fifo: got %0b/%0d expected 0/0", out_valid, fifo_count); end
      checks++; if (IO_read_data !== model_ch[6]) begin errors++; $display("FAIL rst_mid_ch6: got %h expected %h", IO_read_data, model_ch[6]); end
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL rst_mid_ovf: got %0b expected %0b", overflow, model_ovf); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         IO_write_en   = ($urandom_range(0, 9) < 7);
         IO_write_sel  = $urandom_range(0, 1) ? 4'(4 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         IO_write_data = 15'($urandom);
         in_valid      = $urandom_range(0, 1);
         in_chan       = $urandom_range(0, 1) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         in_data       = 15'($urandom);
         out_ready     = ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         ovf_clear     = ($urandom_range(0, 7) == 0);
         IO_read_sel   = $urandom_range(0, 2) == 0 ? IO_write_sel : 4'($urandom_range(0, 15));
         #1;
         checks++; if (IO_read_data !== expected_read(IO_read_sel)) begin errors++; $display("FAIL rnd_read[%0d]: got %h expected %h", n, IO_read_data, expected_read(IO_read_sel)); end
         tick();
         checks++; if (fifo_count !== 3'(exp_q.size()) || out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_fifo[%0d]: got %0d/%0b expected %0d", n, fifo_count, out_valid, exp_q.size()); end
         checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %0b expected %0b", n, overflow, model_ovf); end
         if (exp_q.size() != 0) begin
            checks++; if ({out_chan, out_data} !== exp_q[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %h/%h expected %h", n, out_chan, out_data, exp_q[0]); end
         end
      end
      drive_idle();
   endtask

   initial begin
      reset = 1'b1;
      IO_read_sel = '0;
      drive_idle();
      for (int i = 0; i < 16; i++) model_ch[i] = '0;
      model_ovf = 1'b0;
      #1;
      test_reset();
      test_core_write();
      test_forward_output();
      test_input_channel();
      test_overflow();
      test_full_with_pop();
      test_reset_mid_transfer();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
